// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolutional encoder and its Viterbi decoder.
// Holds the encoder FSM state enum, default code parameters and puncture masks.
// Ports: none (package).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } enc_state_t;

  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;  // octal 7, MSB taps the current input bit
  localparam logic [2:0] G1_DEF = 3'b101;  // octal 5

  // Puncture patterns written as surviving-bit masks over {c1,c0}.
  // Even-phase data symbols keep both bits; odd-phase symbols keep only c0.
  localparam logic [1:0] PUNCT_P0_MASK   = 2'b11;
  localparam logic [1:0] PUNCT_P1_MASK   = 2'b01;
  localparam logic [1:0] PUNCT_TAIL_MASK = 2'b11;

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational rate-1/2 encoder step, shared with the decoder branch-metric unit.
// Ports: i_bit/i_sr (input bit, shift register) -> o_sym {c1,c0}, o_sr_nxt (register after the shift).
// Purely combinational, no clock or reset.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int         K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         i_bit,
  input  logic [K-2:0] i_sr,
  output logic [1:0]   o_sym,
  output logic [K-2:0] o_sr_nxt
);

  logic [K-1:0] w_reg;

  // Newest bit sits in the MSB so the generator MSB taps the current input.
  assign w_reg    = {i_bit, i_sr};
  assign o_sym    = {^(w_reg & G1), ^(w_reg & G0)};
  assign o_sr_nxt = w_reg[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 convolutional encoder, one bit in / one {c1,c0} symbol out,
// each frame zero-terminated with K-1 tail symbols so the decoder ends in state 0.
// Ports: clk, rst (async active-low); ip/ip_valid/ip_ready serial input; op/op_valid/op_ready/op_last
// symbol output; busy while a frame is in progress. Optional CONV_ENC_PUNCT_EN adds op_mask (rate 2/3).
module conv_encoder
  import conv_pkg::*;
#(
  parameter int           K         = K_DEF,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF,
  parameter int           FRAME_LEN = 16,
  parameter int           CNT_W     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ip,
  input  logic       ip_valid,
  output logic       ip_ready,
  output logic [1:0] op,
  output logic       op_valid,
  input  logic       op_ready,
  output logic       op_last,
`ifdef CONV_ENC_PUNCT_EN
  output logic [1:0] op_mask,
`endif
  output logic       busy
);

  enc_state_t   r_state;
  logic [K-2:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]   r_op;
  logic         r_op_vld;
  logic         r_op_last;

  logic         w_out_free;
  logic         w_in_xfer;
  logic         w_flush_step;
  logic         w_load;
  logic         w_bit;
  logic         w_tail_last;
  logic [1:0]   w_sym;
  logic [K-2:0] w_sr_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  // The output register can take a new symbol when empty or being drained this cycle.
  assign w_out_free   = !r_op_vld || op_ready;
  assign ip_ready     = rst && (r_state != FLUSH) && w_out_free;
  assign w_in_xfer    = ip_valid && ip_ready;
  assign w_flush_step = (r_state == FLUSH) && w_out_free;
  assign w_load       = w_in_xfer || w_flush_step;
  assign w_bit        = (r_state == FLUSH) ? 1'b0 : ip;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  // Counter has already advanced once in FLUSH, so this step emits the last tail symbol.
  assign w_tail_last  = (r_state == FLUSH) && (r_cnt == CNT_W'(K - 2));

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .i_bit    (w_bit),
    .i_sr     (r_sr),
    .o_sym    (w_sym),
    .o_sr_nxt (w_sr_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_op      <= 2'b00;
      r_op_vld  <= 1'b0;
      r_op_last <= 1'b0;
    end else begin
      // A fresh symbol always wins over draining: the slot is refilled on the same edge.
      if (w_load) begin
        r_op      <= w_sym;
        r_op_vld  <= 1'b1;
        r_op_last <= w_tail_last;
        r_sr      <= w_sr_nxt;
      end else if (r_op_vld && op_ready) begin
        r_op_vld  <= 1'b0;
        r_op_last <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_in_xfer) begin
            if (FRAME_LEN == 1) begin
              r_state <= FLUSH;
              r_cnt   <= '0;
            end else begin
              r_state <= DATA;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (w_in_xfer) begin
            if (w_cnt_inc == CNT_W'(FRAME_LEN)) begin
              r_state <= FLUSH;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= w_cnt_inc;
            end
          end
        end
        FLUSH: begin
          if (w_flush_step) begin
            if (w_tail_last) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CONV_ENC_PUNCT_EN
  logic       r_phase;
  logic [1:0] r_mask;

  // Phase restarts at each frame's first bit; tail symbols are never punctured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= 1'b0;
      r_mask  <= 2'b00;
    end else if (w_load) begin
      if (r_state == FLUSH) begin
        r_mask  <= PUNCT_TAIL_MASK;
      end else if (r_state == IDLE) begin
        r_mask  <= PUNCT_P0_MASK;
        r_phase <= 1'b1;
      end else begin
        r_mask  <= r_phase ? PUNCT_P1_MASK : PUNCT_P0_MASK;
        r_phase <= ~r_phase;
      end
    end
  end

  assign op_mask = r_mask;
`endif

  assign op       = r_op;
  assign op_valid = r_op_vld;
  assign op_last  = r_op_last;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: scoreboard bench for conv_encoder with FRAME_LEN=4.
// Stimulus pushes hand-computed symbols; a negedge monitor pops and compares on each output transfer.
// Covers reset, back-to-back, output stall, input gaps, reset in FLUSH and frame chaining.
module tb_conv_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ip;
  logic       ip_valid;
  logic       ip_ready;
  logic [1:0] op;
  logic       op_valid;
  logic       op_ready;
  logic       op_last;
  logic       busy;
`ifdef CONV_ENC_PUNCT_EN
  logic [1:0] op_mask;
`endif

  always #5 clk = ~clk;

  conv_encoder #(
    .FRAME_LEN (4),
    .CNT_W     (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ip       (ip),
    .ip_valid (ip_valid),
    .ip_ready (ip_ready),
    .op       (op),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_last  (op_last),
`ifdef CONV_ENC_PUNCT_EN
    .op_mask  (op_mask),
`endif
    .busy     (busy)
  );

  typedef struct packed {
    logic       last;
    logic [1:0] mask;
    logic [1:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sym_cnt = 0;

  // Frame 1,0,1,1 from sr=00, worked by hand with symbols written {c1,c0}:
  //   1:{1,00}->11  0:{0,10}->01  1:{1,01}->00  1:{1,10}->10  tail 0:{0,11}->10  tail 0:{0,01}->11
  logic       frame_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] exp_op     [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
  logic [1:0] exp_mask   [6] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b11};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{last: (i == 5), mask: exp_mask[i], op: exp_op[i]});
    end
  endtask

  // Presents one bit from a negedge until accepted; reports whether the accepting
  // edge also transfers an op_last symbol.
  task automatic send_bit(input logic b, output logic coinc);
    int t = 0;
    coinc = 1'b0;
    @(negedge clk);
    ip       = b;
    ip_valid = 1'b1;
    while (!ip_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ip_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_bit_timeout: ip_ready stayed 0, required 1");
      ip_valid = 1'b0;
    end else begin
      coinc = op_valid && op_ready && op_last;
      @(posedge clk);
      #1;
      ip_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic gap, output logic first_coinc);
    logic c;
    first_coinc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(frame_bits[i], c);
      if (i == 0) first_coinc = c;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({nm, "_left_in_queue"}, 8'(exp_q.size()), 8'd0);
    chk({nm, "_busy_after"},    8'(busy),         8'd0);
    chk({nm, "_op_valid_after"}, 8'(op_valid),    8'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_symbol: got op=%b last=%b, expected no symbol", op, op_last);
        end else begin
          e = exp_q.pop_front();
          chk("sym_op",   8'(op),      8'(e.op));
          chk("sym_last", 8'(op_last), 8'(e.last));
`ifdef CONV_ENC_PUNCT_EN
          chk("sym_mask", 8'(op_mask), 8'(e.mask));
`endif
        end
        sym_cnt++;
      end
    end
  endtask

  task automatic stall_after_second();
    int t = 0;
    int base;
    base = sym_cnt;
    while (!(sym_cnt == base + 1 && op_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_trigger_timeout: second symbol not seen");
    end else begin
      op_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("stall_op_held",  8'(op),       8'(2'b01));
        chk("stall_op_valid", 8'(op_valid), 8'd1);
        chk("stall_ip_ready", 8'(ip_ready), 8'd0);
      end
      @(posedge clk);
      #1;
      op_ready = 1'b1;
    end
  endtask

  task automatic main_seq();
    logic c;
    rst      = 1'b0;
    ip       = 1'b0;
    ip_valid = 1'b0;
    op_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_op",       8'(op),       8'd0);
    chk("rst_op_valid", 8'(op_valid), 8'd0);
    chk("rst_op_last",  8'(op_last),  8'd0);
    chk("rst_busy",     8'(busy),     8'd0);
    chk("rst_ip_ready", 8'(ip_ready), 8'd0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back frame, always ready.
    push_frame();
    send_frame(1'b0, c);
    wait_drain("b2b");

    // Output stalled for 3 cycles while the second symbol is held.
    push_frame();
    fork
      send_frame(1'b0, c);
      stall_after_second();
    join
    wait_drain("stall");

    // ip_valid toggling 1,0,1,0: no bubble symbols.
    push_frame();
    send_frame(1'b1, c);
    wait_drain("gaps");

    // Reset while in FLUSH: aborts the frame without any tail.
    push_frame();
    send_frame(1'b0, c);
    chk("flush_ip_ready", 8'(ip_ready), 8'd0);
    chk("flush_busy",     8'(busy),     8'd1);
    rst = 1'b0;
    #1;
    chk("abort_op_valid", 8'(op_valid), 8'd0);
    chk("abort_op_last",  8'(op_last),  8'd0);
    chk("abort_busy",     8'(busy),     8'd0);
    chk("abort_op",       8'(op),       8'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_frame();
    send_frame(1'b0, c);
    wait_drain("after_abort");

    // Two frames chained: frame 2's first bit accepted on the op_last transfer edge.
    push_frame();
    push_frame();
    send_frame(1'b0, c);
    send_frame(1'b0, c);
    chk("chain_first_bit_on_last", 8'(c), 8'd1);
    wait_drain("chain");
  endtask

  initial begin
    fork
      monitor();
      begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
      end
      main_seq();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
